// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display controller: segment bit
// positions, the all-off pattern and the active-high hex glyph table.
package disp_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;

  // Patterns are {G,F,E,D,C,B,A}, indexed by nibble value
  localparam seg_t HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/disp_mux_ctrl_if.sv
// Datapath-side bus of the display controller: data/control in, pins and status out.
// DISP_BLINK_EN adds the per-digit blink_mask input.
interface disp_mux_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import disp_pkg::*;

  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    blank_lz;
  logic [2:0]              bright;
`ifdef DISP_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  seg_t                    seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;
  logic                    pending;

`ifdef DISP_BLINK_EN
  modport master (output data, dp, load, blank_lz, bright, blink_mask,
                  input seg, dp_out, an, frame_tick, pending);
  modport slave  (input data, dp, load, blank_lz, bright, blink_mask,
                  output seg, dp_out, an, frame_tick, pending);
`else
  modport master (output data, dp, load, blank_lz, bright,
                  input seg, dp_out, an, frame_tick, pending);
  modport slave  (input data, dp, load, blank_lz, bright,
                  output seg, dp_out, an, frame_tick, pending);
`endif

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decoder
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       pattern
);

  assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/disp_mux_ctrl.sv
// Time-multiplexed 7-segment controller with frame-synchronous double buffering,
// leading-zero blanking and PWM dimming. DISP_BLINK_EN enables per-digit blinking.
module disp_mux_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int DIVIDER          = 100000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 0
`ifdef DISP_BLINK_EN
  ,
  parameter int BLINK_FRAMES     = 64
`endif
) (
  input  logic            clk,
  input  logic            rst,
  disp_mux_ctrl_if.slave  bus
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]         CNT_MAX  = CW'(DIVIDER - 1);
  localparam logic [SW-1:0]         SEL_MAX  = SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam seg_t                  SEG_DARK = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_DARK  = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]           count;
  logic [SW-1:0]           sel;
  logic [4*NUM_DIGITS-1:0] stage_data, act_data;
  logic [NUM_DIGITS-1:0]   stage_dp, act_dp;
  logic                    pending_q;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lz_lead;
  logic [31:0]             duty;
  logic                    digit_on;
  logic                    blink_off;
  logic [3:0]              nibble;
  seg_t                    pattern;
  seg_t                    seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  assign frame_end = (count == CNT_MAX) && (sel == SEL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sel   <= '0;
    end else if (count == CNT_MAX) begin
      count <= '0;
      sel   <= (sel == SEL_MAX) ? '0 : sel + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

  // A load in the commit cycle lands in staging after the old contents move to active
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data <= '0;
      stage_dp   <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      pending_q  <= 1'b0;
    end else begin
      if (frame_end && pending_q) begin
        act_data  <= stage_data;
        act_dp    <= stage_dp;
        pending_q <= 1'b0;
      end
      if (bus.load) begin
        stage_data <= bus.data;
        stage_dp   <= bus.dp;
        pending_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    lz_lead  = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_lead     = lz_lead && (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
      lz_blank[i] = bus.blank_lz && lz_lead && (i != 0);
    end
  end

`ifdef DISP_BLINK_EN
  logic [31:0] frame_cnt;
  logic        blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == 32'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

  assign blink_off = blink_phase && bus.blink_mask[sel];
`else
  assign blink_off = 1'b0;
`endif

  assign duty     = (32'(bus.bright) + 32'd1) * 32'(DIVIDER / 8);
  assign nibble   = act_data[4*sel +: 4];
  assign digit_on = (32'(count) < duty) && !lz_blank[sel] && !blink_off;

  seg7_hex_decoder u_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  // XOR against the dark constants applies pin polarity in one place
  always_ff @(posedge clk) begin
    if (rst || !digit_on) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_DARK;
      dp_q  <= DP_DARK;
    end else begin
      an_q  <= AN_OFF ^ (NUM_DIGITS'(1) << sel);
      seg_q <= pattern ^ SEG_DARK;
      dp_q  <= act_dp[sel] ^ DP_DARK;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_end;
  assign bus.pending    = pending_q;

endmodule
